// File: rtl/xlr_mem_arb.sv
// rtl/xlr_mem_arb.sv - two-requester arbiter in front of a bank of XLR memories
module xlr_mem_arb #(
  parameter int NUM_MEMS           = 2,
  parameter int LOG2_LINES_PER_MEM = 8,
  parameter int DATA_W             = 32,
  parameter int MAX_BURST          = 8,
  localparam int BE_W  = DATA_W / 8,
  localparam int MEM_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1,
  localparam int AW    = LOG2_LINES_PER_MEM
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   i_rq_valid,
  input  logic [1:0]                   i_rq_wr,
  input  logic [2*MEM_W-1:0]           i_rq_mem,
  input  logic [2*AW-1:0]              i_rq_addr,
  input  logic [2*DATA_W-1:0]          i_rq_wdata,
  input  logic [2*BE_W-1:0]            i_rq_be,
  input  logic [1:0]                   i_rq_lock,
  output logic [1:0]                   o_rq_ready,
  output logic [1:0]                   o_rsp_valid,
  output logic [DATA_W-1:0]            o_rsp_rdata,
  output logic [NUM_MEMS*AW-1:0]       o_mem_addr,
  output logic [NUM_MEMS*DATA_W-1:0]   o_mem_wdata,
  output logic [NUM_MEMS*BE_W-1:0]     o_mem_be,
  output logic [NUM_MEMS-1:0]          o_mem_rd,
  output logic [NUM_MEMS-1:0]          o_mem_wr,
  input  logic [NUM_MEMS*DATA_W-1:0]   i_mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_last_grant;
  logic             r_rd_pend;
  logic             r_rd_idx;
  logic [MEM_W-1:0] r_rd_mem;

  logic [1:0]        w_nxt;
  logic              w_own_vld;
  logic              w_own;
  logic              w_acc;
  logic              w_oth_vld;
  logic [1:0]        w_oth_state;
  logic              w_own_lock;
  logic              w_wr;
  logic [MEM_W-1:0]  w_mem;
  logic [AW-1:0]     w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_be;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_burst_done;

  // Owner selection and the owner's request fields
  assign w_own_vld   = (r_state == ST_OWN0) || (r_state == ST_OWN1);
  assign w_own       = (r_state == ST_OWN1);
  assign w_acc       = w_own_vld && i_rq_valid[w_own];
  assign w_oth_vld   = i_rq_valid[~w_own];
  assign w_oth_state = w_own ? ST_OWN0 : ST_OWN1;
  assign w_own_lock  = i_rq_lock[w_own];
  assign w_wr        = i_rq_wr[w_own];
  assign w_mem       = w_own ? i_rq_mem[MEM_W +: MEM_W]     : i_rq_mem[0 +: MEM_W];
  assign w_addr      = w_own ? i_rq_addr[AW +: AW]          : i_rq_addr[0 +: AW];
  assign w_wdata     = w_own ? i_rq_wdata[DATA_W +: DATA_W] : i_rq_wdata[0 +: DATA_W];
  assign w_be        = w_own ? i_rq_be[BE_W +: BE_W]        : i_rq_be[0 +: BE_W];

  // Burst count saturates so a solo locked owner never wraps
  assign w_cnt_inc    = (r_burst_cnt == CNT_W'(MAX_BURST)) ? r_burst_cnt : r_burst_cnt + 1'b1;
  assign w_burst_done = (w_cnt_inc == CNT_W'(MAX_BURST));

  assign o_rq_ready  = {w_acc & w_own, w_acc & ~w_own};
  assign o_rsp_valid = {r_rd_pend & r_rd_idx, r_rd_pend & ~r_rd_idx};

  // Next-state: round-robin from idle, hand over on unlock, idle or burst limit
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_rq_valid == 2'b11)  w_nxt = r_last_grant ? ST_OWN0 : ST_OWN1;
        else if (i_rq_valid[0])   w_nxt = ST_OWN0;
        else if (i_rq_valid[1])   w_nxt = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (!w_acc)                                     w_nxt = w_oth_vld ? w_oth_state : ST_IDLE;
        else if (w_oth_vld && (!w_own_lock || w_burst_done)) w_nxt = w_oth_state;
        else if (!w_own_lock)                           w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Ownership state, last grant and burst counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_burst_cnt  <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_nxt;
      if ((w_nxt != r_state) && (w_nxt != ST_IDLE)) r_last_grant <= (w_nxt == ST_OWN1);
      if (w_acc && (w_nxt == r_state)) r_burst_cnt <= w_cnt_inc;
      else                             r_burst_cnt <= '0;
    end
  end

  // Remember who issued the accepted read so the next cycle can route its data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_rd_idx  <= 1'b0;
      r_rd_mem  <= '0;
    end else begin
      r_rd_pend <= w_acc && !w_wr;
      r_rd_idx  <= w_own;
      r_rd_mem  <= w_mem;
    end
  end

  // Drive only the addressed memory; an out-of-range index touches nothing
  always_comb begin
    o_mem_rd    = '0;
    o_mem_wr    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    for (int m = 0; m < NUM_MEMS; m++) begin
      if (w_acc && (32'(w_mem) == m)) begin
        o_mem_rd[m]                     = ~w_wr;
        o_mem_wr[m]                     = w_wr;
        o_mem_addr[m*AW +: AW]          = w_addr;
        o_mem_wdata[m*DATA_W +: DATA_W] = w_wdata;
        o_mem_be[m*BE_W +: BE_W]        = w_be;
      end
    end
  end

  // Read data mux; zero when idle or when the read targeted a missing memory
  always_comb begin
    o_rsp_rdata = '0;
    for (int m = 0; m < NUM_MEMS; m++) begin
      if (r_rd_pend && (32'(r_rd_mem) == m)) o_rsp_rdata = i_mem_rdata[m*DATA_W +: DATA_W];
    end
  end

endmodule
